dynamic_compressor: RTL and testbench
=====================================

Name: dynamic_compressor

Overview:
- Parametrised multi-channel compressor/limiter for the audio effects chain, placed between the codec receive path and the output mixer.
- Per channel, tracks a moving-average magnitude envelope over a power-of-two window.
- When both the envelope and the instantaneous magnitude exceed a programmable threshold, it applies one of three modes:
  - compression, with a shift ratio;
  - hard limiting;
  - average replacement.
- Samples arrive with a valid strobe and leave with a fixed latency of 2 cycles.

Parameters:
- DATA_W, 32, sample width, signed two's complement, minimum 8.
- NUM_CH, 2, number of channels processed in parallel.
- AVG_LOG2, 4, envelope window is 2^AVG_LOG2 samples, range 1..6.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  one sample per channel is presented this cycle.
- in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- threshold  in  DATA_W-1  unsigned magnitude threshold.
- ratio_sh  in  5  compression ratio is 2^ratio_sh.
- mode  in  2  00 bypass, 01 compress, 10 limit, 11 average.
- out_valid  out  1  single-cycle pulse, 2 cycles after in_valid.
- out_data  out  NUM_CH*DATA_W  processed samples, same packing as in_data.
- gr_active  out  NUM_CH  gain reduction applied to this output sample, per channel.

Behaviour:
- Reset (synchronous, active-high, on clock):
  - out_valid=0, out_data=0, gr_active=0.
  - All window buffers=0, running sums=0, write pointer=0, pipeline valids=0.
  - In-flight samples are discarded; the first output after reset comes from the first in_valid after reset.
- Stage 1 (on in_valid):
  - Per channel, mag = |x|. x = -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
  - sum <= sum + mag - buf[wr_ptr]; buf[wr_ptr] <= mag.
  - The sample, mag, threshold, ratio_sh and mode are registered. Config is sampled per sample, so mid-stream changes take effect cleanly on the next in_valid.
- Shared wr_ptr increments on each in_valid and wraps from 2^AVG_LOG2-1 to 0.
- sum width is DATA_W-1+AVG_LOG2, so it cannot overflow.
- Stage 2:
  - env = updated sum >> AVG_LOG2, which includes the current sample.
  - The buffer is zero-filled at reset, so during warm-up the envelope ramps up (no special case).
  - over = (env > thr) && (mag > thr). Equality is not over.
  - The out_mag rules below apply only when over=1; when over=0, output = input and gr_active=0.
  - mode 00: output = input, gr_active=0, regardless of over.
  - mode 01: out_mag = thr + ((mag-thr) >> ratio_sh). If ratio_sh >= DATA_W-1 the excess term is 0.
  - mode 10: out_mag = thr.
  - mode 11: out_mag = min(env, mag).
  - The sign of the input is restored: negative input gives -out_mag.
  - gr_active[c] = over for modes 01/10/11.
- Timing:
  - out_valid is high exactly 2 cycles after in_valid; back-to-back in_valid every cycle is supported.
  - There is no backpressure.
  - out_data and gr_active hold their values between pulses.
- in_valid=0 cycles do not advance wr_ptr or alter sums.
- in_valid asserted on the same cycle reset deasserts is accepted; while reset=1, in_valid is ignored.
- Channels are fully independent except for the shared wr_ptr and the shared config.

Decomposition:
- Package compressor_pkg:
  - mode_e enum (MODE_BYPASS, MODE_COMP, MODE_LIMIT, MODE_AVG);
  - function abs_sat(x) returning saturated magnitude;
  - localparam helpers for sum width.
- Sub-module comp_channel: one channel's window buffer, running sum, envelope and gain stage.
  - Takes wr_ptr, the sample strobe and registered config as inputs.
  - Instantiated NUM_CH times by generate in dynamic_compressor, which owns wr_ptr, config registers and the valid pipeline.

Test Plan:
All scenarios use DATA_W=16, NUM_CH=2, AVG_LOG2=2, threshold=1000, ratio_sh=2.
1. Warm-up compress, mode 01: ch0 fed 3000 on four consecutive valids.
   - Outputs: 3000 (env 750, no gr), then 1500, 1500, 1500 with gr_active[0]=1.
   - out_valid occurs 2 cycles after each in_valid.
2. Sign and limit, mode 10: ch1 fed -3000 ×4.
   - Outputs: -3000, then -1000 ×3.
   - Meanwhile ch0 fed 500 gives 500 unchanged with gr_active[0]=0.
3. Saturation and average, mode 11: ch0 fed -32768 ×4.
   - env sequence: 8191, 16383, 24575, 32767.
   - Outputs: -8191, -16383, -24575, -32767.
4. Window wrap and decay, mode 01:
   - Feed 4000 ×4, then 0 ×3, then 4000.
   - Zeros output 0.
   - Last sample has env 1000, which is not > thr, so the output is 4000 uncompressed.
5. Bypass and config change:
   - mode 00 with 3000 ×4 gives 3000 ×4.
   - Switching to mode 01 on the 5th valid gives 1500 on that exact sample.
   - ratio_sh=31 gives 1000.
6. Reset mid-stream: assert reset 1 cycle between two valids of 3000.
   - The pending output is dropped and out_valid=0.
   - The next 3000 after reset outputs 3000 (env 750), proving buffer/sum clear.

Source files
------------

// File: rtl/dynamic_compressor_pkg.sv
// Shared types and helpers for the dynamic compressor: mode encoding,
// running-sum width and saturating magnitude.
package compressor_pkg;

  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_COMP   = 2'b01,
    MODE_LIMIT  = 2'b10,
    MODE_AVG    = 2'b11
  } mode_e;

  function automatic int sum_w(input int data_w, input int avg_log2);
    return data_w - 1 + avg_log2;
  endfunction

  // The most negative input has no positive twin; clamp it to the largest magnitude.
  function automatic logic [MAX_W-1:0] abs_sat(input logic signed [MAX_W-1:0] x,
                                               input int data_w);
    logic [MAX_W-1:0] lim;
    logic [MAX_W-1:0] m;
    lim = (MAX_W'(1) << (data_w - 1)) - MAX_W'(1);
    m   = x[MAX_W-1] ? MAX_W'(-x) : MAX_W'(x);
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/dynamic_compressor_channel.sv
// One compressor channel: window buffer, running sum, envelope and gain stage.
module comp_channel
  import compressor_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int AVG_LOG2 = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                smp_vld,
  input  logic [AVG_LOG2-1:0] wr_ptr,
  input  logic [DATA_W-1:0]   in_smp,
  input  logic                vld_p1,
  input  logic [DATA_W-2:0]   thr_p1,
  input  logic [4:0]          ratio_p1,
  input  logic [1:0]          mode_p1,
  output logic [DATA_W-1:0]   out_smp,
  output logic                gr_active
);

  localparam int SUM_W = sum_w(DATA_W, AVG_LOG2);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int MAG_W = DATA_W - 1;

  logic [MAG_W-1:0]         win_q [DEPTH];
  logic [MAG_W-1:0]         win_d [DEPTH];
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic signed [DATA_W-1:0] x_p1_q, x_p1_d;
  logic [MAG_W-1:0]         mag_p1_q, mag_p1_d;
  logic [DATA_W-1:0]        out_q, out_d;
  logic                     gr_q, gr_d;
  logic [MAG_W-1:0]         mag_c, env_c, omag_c;
  logic                     over_c;
  mode_e                    mode_c;

  function automatic logic [MAG_W-1:0] gain_mag(input logic [MAG_W-1:0] mag,
                                                input logic [MAG_W-1:0] env,
                                                input logic [MAG_W-1:0] thr,
                                                input logic [4:0]       ratio,
                                                input mode_e            m);
    logic [MAG_W-1:0] excess;
    excess = mag - thr;
    case (m)
      MODE_COMP:  return thr + ((int'(ratio) >= MAG_W) ? '0 : (excess >> ratio));
      MODE_LIMIT: return thr;
      MODE_AVG:   return (env < mag) ? env : mag;
      default:    return mag;
    endcase
  endfunction

  // Stage 1: magnitude, window update and running sum
  always_comb begin
    mag_c    = MAG_W'(abs_sat(MAX_W'(signed'(in_smp)), DATA_W));
    win_d    = win_q;
    sum_d    = sum_q;
    x_p1_d   = x_p1_q;
    mag_p1_d = mag_p1_q;
    if (smp_vld) begin
      win_d[wr_ptr] = mag_c;
      sum_d         = sum_q + SUM_W'(mag_c) - SUM_W'(win_q[wr_ptr]);
      x_p1_d        = signed'(in_smp);
      mag_p1_d      = mag_c;
    end
  end

  // Stage 2: envelope includes the sample just accumulated into sum_q
  assign env_c  = sum_q[SUM_W-1:AVG_LOG2];
  assign mode_c = mode_e'(mode_p1);

  always_comb begin
    out_d  = out_q;
    gr_d   = gr_q;
    over_c = (env_c > thr_p1) && (mag_p1_q > thr_p1);
    omag_c = gain_mag(mag_p1_q, env_c, thr_p1, ratio_p1, mode_c);
    if (vld_p1) begin
      if (over_c && (mode_c != MODE_BYPASS)) begin
        out_d = x_p1_q[DATA_W-1] ? -{1'b0, omag_c} : {1'b0, omag_c};
        gr_d  = 1'b1;
      end else begin
        out_d = x_p1_q;
        gr_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      sum_q <= '0;
      out_q <= '0;
      gr_q  <= 1'b0;
    end else begin
      win_q <= win_d;
      sum_q <= sum_d;
      out_q <= out_d;
      gr_q  <= gr_d;
    end
  end

  always_ff @(posedge clock) begin
    x_p1_q   <= x_p1_d;
    mag_p1_q <= mag_p1_d;
  end

  assign out_smp   = out_q;
  assign gr_active = gr_q;

endmodule

// File: rtl/dynamic_compressor.sv
// Multi-channel compressor/limiter top: shared write pointer, per-sample
// config capture and valid pipeline around NUM_CH independent channels.
module dynamic_compressor
  import compressor_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 2,
  parameter int AVG_LOG2 = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [DATA_W-2:0]        threshold,
  input  logic [4:0]               ratio_sh,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        gr_active
);

  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                vld_p1_q, vld_p1_d;
  logic                vld_p2_q, vld_p2_d;
  logic [DATA_W-2:0]   thr_p1_q, thr_p1_d;
  logic [4:0]          ratio_p1_q, ratio_p1_d;
  logic [1:0]          mode_p1_q, mode_p1_d;

  // Stage 1: config travels with the sample so mid-stream changes land cleanly
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    thr_p1_d   = thr_p1_q;
    ratio_p1_d = ratio_p1_q;
    mode_p1_d  = mode_p1_q;
    vld_p1_d   = in_valid;
    vld_p2_d   = vld_p1_q;
    if (in_valid) begin
      wr_ptr_d   = wr_ptr_q + AVG_LOG2'(1);
      thr_p1_d   = threshold;
      ratio_p1_d = ratio_sh;
      mode_p1_d  = mode;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clock) begin
    thr_p1_q   <= thr_p1_d;
    ratio_p1_q <= ratio_p1_d;
    mode_p1_q  <= mode_p1_d;
  end

  // Stage 2: channel outputs register on vld_p1
  assign out_valid = vld_p2_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    comp_channel #(
      .DATA_W  (DATA_W),
      .AVG_LOG2(AVG_LOG2)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .smp_vld  (in_valid),
      .wr_ptr   (wr_ptr_q),
      .in_smp   (in_data[c*DATA_W +: DATA_W]),
      .vld_p1   (vld_p1_q),
      .thr_p1   (thr_p1_q),
      .ratio_p1 (ratio_p1_q),
      .mode_p1  (mode_p1_q),
      .out_smp  (out_data[c*DATA_W +: DATA_W]),
      .gr_active(gr_active[c])
    );
  end

endmodule

// File: tb/tb_dynamic_compressor.sv
// Directed scoreboard bench for dynamic_compressor (DATA_W=16, NUM_CH=2, AVG_LOG2=2).
module tb_dynamic_compressor;

  localparam int DATA_W   = 16;
  localparam int NUM_CH   = 2;
  localparam int AVG_LOG2 = 2;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic [31:0] in_data   = '0;
  logic [14:0] threshold = 15'd1000;
  logic [4:0]  ratio_sh  = 5'd2;
  logic [1:0]  mode      = 2'b00;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  gr_active;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  gr;
    int          stamp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  dynamic_compressor #(
    .DATA_W  (DATA_W),
    .NUM_CH  (NUM_CH),
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .threshold(threshold),
    .ratio_sh (ratio_sh),
    .mode     (mode),
    .out_valid(out_valid),
    .out_data (out_data),
    .gr_active(gr_active)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed hang expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_out_valid: observed 1 expected 0");
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("gr_active", 32'(gr_active), 32'(e.gr));
        chk("latency", 32'(cyc), 32'(e.stamp + 2));
      end
    end
  end

  task automatic send(input int c0, input int c1, input int e0, input int e1,
                      input logic [1:0] g, input bit push);
    exp_t e;
    in_valid = 1'b1;
    in_data  = {16'(c1), 16'(c0)};
    if (push) begin
      e.data  = {16'(e1), 16'(e0)};
      e.gr    = g;
      e.stamp = cyc;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d pending outputs expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clock); #1;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_gr_active", 32'(gr_active), 32'd0);

    // Warm-up compress
    mode = 2'b01;
    send(3000, 0, 3000, 0, 2'b00, 1);
    repeat (3) send(3000, 0, 1500, 0, 2'b01, 1);
    drain();
    do_reset();

    // Sign restore and hard limit on ch1, ch0 below threshold
    mode = 2'b10;
    send(500, -3000, 500, -3000, 2'b00, 1);
    repeat (3) send(500, -3000, 500, -1000, 2'b10, 1);
    drain();
    do_reset();

    // Most-negative input saturates; average mode follows the envelope
    mode = 2'b11;
    send(-32768, 0, -8191, 0, 2'b01, 1);
    send(-32768, 0, -16383, 0, 2'b01, 1);
    send(-32768, 0, -24575, 0, 2'b01, 1);
    send(-32768, 0, -32767, 0, 2'b01, 1);
    drain();
    do_reset();

    // Window wrap and decay; env equal to threshold is not over
    mode = 2'b01;
    send(4000, 0, 4000, 0, 2'b00, 1);
    repeat (3) send(4000, 0, 1750, 0, 2'b01, 1);
    repeat (3) send(0, 0, 0, 0, 2'b00, 1);
    send(4000, 0, 4000, 0, 2'b00, 1);
    drain();
    do_reset();

    // Bypass, then per-sample config changes
    mode = 2'b00;
    repeat (4) send(3000, 0, 3000, 0, 2'b00, 1);
    mode = 2'b01;
    send(3000, 0, 1500, 0, 2'b01, 1);
    ratio_sh = 5'd31;
    send(3000, 0, 1000, 0, 2'b01, 1);
    ratio_sh = 5'd2;
    drain();
    do_reset();

    // Reset between two valids drops the in-flight sample and clears the window
    mode = 2'b01;
    send(3000, -3000, 0, 0, 2'b00, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("drop_out_valid", 32'(out_valid), 32'd0);
    chk("drop_out_data", out_data, 32'd0);
    reset = 1'b0;
    send(3000, -3000, 3000, -3000, 2'b00, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
